seq_signed_divider: RTL and testbench
=====================================

// Module: seq_signed_divider
// PURPOSE
//  Iterative two's-complement divider: 2*DW-bit signed dividend / DW-bit signed divisor -> quotient, remainder.
//  Inverse datapath to the team's 8x8 signed array/Wallace multiplier; accepts its 16-bit product format directly.
//  Restoring algorithm on magnitudes, one quotient bit per clock, valid/ready handshake on both sides.
// PARAMETERS
//  DW   8   divisor/remainder width; dividend and quotient are 2*DW bits
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      synchronous reset, active-high
//  in_valid     in   1      dividend/divisor valid
//  in_ready     out  1      block can accept an operation (high only in IDLE)
//  dividend     in   2*DW   signed dividend
//  divisor      in   DW     signed divisor
//  out_valid    out  1      result valid; held until out_ready
//  out_ready    in   1      consumer accepts result
//  quotient     out  2*DW   signed quotient, truncated toward zero
//  remainder    out  DW     signed remainder, sign of dividend (or zero)
//  div_by_zero  out  1      divisor was 0
//  overflow     out  1      quotient not representable (dividend = -2^(2DW-1), divisor = -1)
// BEHAVIOUR
//  Single clock; reset synchronous, active-high. On rst: state IDLE, in_ready=1, out_valid=0, quotient=0,
//   remainder=0, div_by_zero=0, overflow=0. Reset mid-operation aborts; no result ever emitted for it.
//  FSM: IDLE -(in_valid&&in_ready)-> CALC -(2*DW steps)-> FIX -> DONE -(out_ready)-> IDLE.
//  IDLE: capture |dividend|, |divisor|, sign(dividend), sign(dividend)^sign(divisor); partial remainder=0.
//  CALC: per cycle shift next dividend MSB into partial remainder (DW+1 bits); if rem>=|divisor| subtract, q bit=1.
//   Iteration counter 0..2*DW-1; exits on count==2*DW-1.
//  FIX: negate quotient if signs differ; negate remainder if dividend negative; set flags; outputs registered.
//  DONE: out_valid=1; quotient/remainder/flags stable while out_valid && !out_ready.
//  Latency: accept at cycle N -> out_valid first high at N+2*DW+2 (18 for DW=8). No back-to-back acceptance:
//   in_ready=0 in CALC/FIX/DONE; returns high the cycle after the out_valid&&out_ready handshake.
//  Width rules: |dividend| held in 2*DW bits (|-2^(2DW-1)| = 2^(2DW-1) fits unsigned); |divisor| DW bits unsigned.
//  Overflow case: quotient=2^(2DW-1) (0x8000 for DW=8), remainder=0, overflow=1.
//  Divide-by-zero: quotient=all ones, remainder=0, div_by_zero=1, overflow=0.
//  |remainder| < |divisor| <= 2^(DW-1), so remainder always fits DW bits signed.
// CONFIGURATION
//  SDIV_ZERO_BYPASS_EN defined: divisor==0 detected at acceptance; FSM goes IDLE->FIX->DONE, out_valid at N+2.
//  Undefined: zero divisor runs full CALC sequence (latency 2*DW+2); FIX forces the same result values/flags.
//  Result values and flags identical either way; only latency differs.
// STRUCTURE
//  Shared package mul_div_pkg: FSM state enum (IDLE/CALC/FIX/DONE), DW default, abs/negate helper functions
//   reused by multiplier testbenches.
//  Sub-module div_step: combinational restoring step (shift-in bit, DW+1-bit trial subtract, q bit, next rem).
//  Top holds FSM, counter, operand/sign registers, output registers.
// TESTING
//  dividend=100, divisor=7 -> quotient=14, remainder=2, flags 0, out_valid at acceptance+18.
//  dividend=-100 (0xFF9C), divisor=7 -> quotient=0xFFF2 (-14), remainder=0xFE (-2).
//  dividend=0x8000, divisor=0xFF -> quotient=0x8000, remainder=0, overflow=1.
//  dividend=1234, divisor=0 -> quotient=0xFFFF, remainder=0, div_by_zero=1; latency 2 with SDIV_ZERO_BYPASS_EN, 18 without.
//  Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; rst at cycle 5 of CALC -> next cycle
//   in_ready=1, out_valid=0, no result emitted.
//  1000 random signed a,b (b!=0): dividend=a*b, divisor=b -> quotient==sign-extended a, remainder==0.

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared types and helpers for the signed multiply/divide datapaths.
// Holds the divider FSM state encoding, the default operand width and
// two's-complement abs/negate helpers sized for the default width.
package mul_div_pkg;

   localparam int DIV_DW = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } div_state_t;

   function automatic logic [DIV_DW-1:0] neg_n(input logic [DIV_DW-1:0] x);
      return ~x + 1'b1;
   endfunction

   function automatic logic [2*DIV_DW-1:0] neg_2n(input logic [2*DIV_DW-1:0] x);
      return ~x + 1'b1;
   endfunction

   function automatic logic [DIV_DW-1:0] abs_n(input logic [DIV_DW-1:0] x);
      return x[DIV_DW-1] ? neg_n(x) : x;
   endfunction

   function automatic logic [2*DIV_DW-1:0] abs_2n(input logic [2*DIV_DW-1:0] x);
      return x[2*DIV_DW-1] ? neg_2n(x) : x;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step on magnitudes.
// Shifts the next dividend bit into the partial remainder, trial-subtracts
// the divisor magnitude and keeps the difference when it does not go negative.
// The incoming remainder is always below |divisor| <= 2^(DW-1), so its MSB is
// never needed for the shift; the widened DW+1-bit value is what is compared.
module div_step #(
   parameter int DW = 8
) (
   input  logic [DW:0]   rem_i,
   input  logic          bit_i,
   input  logic [DW-1:0] dvs_i,
   output logic [DW:0]   rem_o,
   output logic          q_o
);

   logic [DW:0] shifted;
   logic [DW:0] trial;
   logic        unused_rem_msb;

   assign unused_rem_msb = rem_i[DW];

   // Shift, trial subtract, and restore when the divisor does not fit
   always_comb begin
      shifted = {rem_i[DW-1:0], bit_i};
      trial   = shifted - {1'b0, dvs_i};
      q_o     = (shifted >= {1'b0, dvs_i});
      rem_o   = q_o ? trial : shifted;
   end

endmodule

// File: rtl/seq_signed_divider.sv
// Iterative signed divider: 2*DW-bit dividend / DW-bit divisor, one quotient
// bit per clock, valid/ready on both sides.
// Optional macro SDIV_ZERO_BYPASS_EN: a zero divisor skips the CALC phase.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operation
// CALC  | 2*DW restoring steps on operand magnitudes
// FIX   | apply signs, special cases, load output registers
// DONE  | out_valid high, result held until out_ready
module seq_signed_divider
   import mul_div_pkg::*;
#(
   parameter int DW = DIV_DW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2*DW-1:0] dividend,
   input  logic [DW-1:0]   divisor,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2*DW-1:0] quotient,
   output logic [DW-1:0]   remainder,
   output logic            div_by_zero,
   output logic            overflow
);

   localparam int QW = 2 * DW;
   localparam int CW = $clog2(QW);
   localparam logic [CW-1:0] CNT_LAST = CW'(QW - 1);
   localparam logic [QW-1:0] Q_MIN    = {1'b1, {(QW-1){1'b0}}};

   div_state_t    state_q, state_d;
   logic [QW-1:0] dq_q, dq_d;
   logic [DW:0]   rem_q, rem_d;
   logic [DW-1:0] dvs_q, dvs_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          qneg_q, qneg_d;
   logic          rneg_q, rneg_d;
   logic          dz_q, dz_d;
   logic          ov_q, ov_d;
   logic [QW-1:0] quo_q, quo_d;
   logic [DW-1:0] rmd_q, rmd_d;
   logic          dzo_q, dzo_d;
   logic          ovo_q, ovo_d;

   logic          dvd_neg, dvs_neg;
   logic [QW-1:0] dvd_abs;
   logic [DW-1:0] dvs_abs;
   logic          zero_in, ovf_in;
   logic [DW:0]   step_rem;
   logic          step_q;
   logic          unused_rem_top;

   assign dvd_neg = dividend[QW-1];
   assign dvs_neg = divisor[DW-1];
   assign dvd_abs = dvd_neg ? (~dividend + 1'b1) : dividend;
   assign dvs_abs = dvs_neg ? (~divisor + 1'b1) : divisor;
   assign zero_in = (divisor == '0);
   assign ovf_in  = (dividend == Q_MIN) && (divisor == '1);

   // The remainder left after the last step is below |divisor|, so the MSB
   // carries nothing into the signed result.
   assign unused_rem_top = rem_q[DW];

   div_step #(.DW(DW)) u_step (
      .rem_i (rem_q),
      .bit_i (dq_q[QW-1]),
      .dvs_i (dvs_q),
      .rem_o (step_rem),
      .q_o   (step_q)
   );

   assign in_ready    = (state_q == ST_IDLE);
   assign out_valid   = (state_q == ST_DONE);
   assign quotient    = quo_q;
   assign remainder   = rmd_q;
   assign div_by_zero = dzo_q;
   assign overflow    = ovo_q;

   // Next-state, datapath and result-register update
   always_comb begin
      state_d = state_q;
      dq_d    = dq_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      ov_d    = ov_q;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
      dzo_d   = dzo_q;
      ovo_d   = ovo_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               dq_d   = dvd_abs;
               dvs_d  = dvs_abs;
               rem_d  = '0;
               cnt_d  = '0;
               qneg_d = dvd_neg ^ dvs_neg;
               rneg_d = dvd_neg;
               dz_d   = zero_in;
               ov_d   = ovf_in;
`ifdef SDIV_ZERO_BYPASS_EN
               state_d = zero_in ? ST_FIX : ST_CALC;
`else
               state_d = ST_CALC;
`endif
            end
         end
         ST_CALC: begin
            // The dividend register doubles as the quotient shift register.
            dq_d  = {dq_q[QW-2:0], step_q};
            rem_d = step_rem;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            if (dz_q) begin
               quo_d = '1;
               rmd_d = '0;
               dzo_d = 1'b1;
               ovo_d = 1'b0;
            end else if (ov_q) begin
               quo_d = Q_MIN;
               rmd_d = '0;
               dzo_d = 1'b0;
               ovo_d = 1'b1;
            end else begin
               quo_d = qneg_q ? (~dq_q + 1'b1) : dq_q;
               rmd_d = rneg_q ? (~rem_q[DW-1:0] + 1'b1) : rem_q[DW-1:0];
               dzo_d = 1'b0;
               ovo_d = 1'b0;
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         dq_q    <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         ov_q    <= 1'b0;
         quo_q   <= '0;
         rmd_q   <= '0;
         dzo_q   <= 1'b0;
         ovo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dq_q    <= dq_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
         ov_q    <= ov_d;
         quo_q   <= quo_d;
         rmd_q   <= rmd_d;
         dzo_q   <= dzo_d;
         ovo_q   <= ovo_d;
      end
   end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider (DW=8): directed vector table,
// held-output and mid-operation reset sequences, and random exact divisions.
module tb_seq_signed_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        div_by_zero;
   logic        overflow;

   int n_chk = 0;
   int n_err = 0;

`ifdef SDIV_ZERO_BYPASS_EN
   localparam int ZLAT = 2;
`else
   localparam int ZLAT = 18;
`endif
   localparam int LAT = 18;

   typedef struct {
      logic [15:0] dvd;
      logic [7:0]  dvs;
      logic [15:0] q;
      logic [7:0]  r;
      logic        dz;
      logic        ov;
   } vec_t;

   vec_t exp_q[$];
   vec_t tbl[14];

   always #5 clk = ~clk;

   seq_signed_divider #(.DW(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [15:0] dvd, input logic [7:0] dvs,
                               input logic [15:0] q, input logic [7:0] r,
                               input logic dz, input logic ov);
      vec_t v;
      v.dvd = dvd; v.dvs = dvs; v.q = q; v.r = r; v.dz = dz; v.ov = ov;
      return v;
   endfunction

   task automatic run_op(input vec_t v, input int hold);
      vec_t e;
      int   n;
      int   lat;
      int   exp_lat;
      exp_lat = v.dz ? ZLAT : LAT;
      @(negedge clk);
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("in_ready_wait", 32'(in_ready), 32'd1);
         return;
      end
      exp_q.push_back(v);
      dividend = v.dvd;
      divisor  = v.dvs;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      dividend = 16'h5A5A;
      divisor  = 8'h33;
      lat = 0;
      n   = 0;
      while (lat == 0 && n < 40) begin
         @(negedge clk);
         n++;
         if (out_valid) lat = n;
      end
      e = exp_q.pop_front();
      chk("latency", 32'(lat), 32'(exp_lat));
      if (lat == 0) return;
      chk("quotient", 32'(quotient), 32'(e.q));
      chk("remainder", 32'(remainder), 32'(e.r));
      chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
      chk("overflow", 32'(overflow), 32'(e.ov));
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_quotient", 32'(quotient), 32'(e.q));
         chk("hold_remainder", 32'(remainder), 32'(e.r));
         chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("in_ready_after", 32'(in_ready), 32'd1);
      chk("out_valid_after", 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic signed [7:0]  sa;
      logic signed [7:0]  sb;
      logic signed [15:0] prod;
      int                 seen;

      tbl[0]  = mk(16'd100,  8'd7,    16'd14,   8'd2,    1'b0, 1'b0);
      tbl[1]  = mk(16'hFF9C, 8'd7,    16'hFFF2, 8'hFE,   1'b0, 1'b0);
      tbl[2]  = mk(16'h8000, 8'hFF,   16'h8000, 8'h00,   1'b0, 1'b1);
      tbl[3]  = mk(16'd1234, 8'd0,    16'hFFFF, 8'h00,   1'b1, 1'b0);
      tbl[4]  = mk(16'hFFFB, 8'd0,    16'hFFFF, 8'h00,   1'b1, 1'b0);
      tbl[5]  = mk(16'd7,    8'hFE,   16'hFFFD, 8'h01,   1'b0, 1'b0);
      tbl[6]  = mk(16'hFFF9, 8'hFE,   16'h0003, 8'hFF,   1'b0, 1'b0);
      tbl[7]  = mk(16'h7FFF, 8'h80,   16'hFF01, 8'h7F,   1'b0, 1'b0);
      tbl[8]  = mk(16'h8000, 8'h80,   16'h0100, 8'h00,   1'b0, 1'b0);
      tbl[9]  = mk(16'h8000, 8'h01,   16'h8000, 8'h00,   1'b0, 1'b0);
      tbl[10] = mk(16'd0,    8'd5,    16'h0000, 8'h00,   1'b0, 1'b0);
      tbl[11] = mk(16'd5,    8'd100,  16'h0000, 8'h05,   1'b0, 1'b0);
      tbl[12] = mk(16'h7FFF, 8'h7F,   16'h0102, 8'h01,   1'b0, 1'b0);
      tbl[13] = mk(16'hFFFF, 8'hFF,   16'h0001, 8'h00,   1'b0, 1'b0);

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_quotient", 32'(quotient), 32'd0);
      chk("rst_remainder", 32'(remainder), 32'd0);
      chk("rst_div_by_zero", 32'(div_by_zero), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);

      for (int i = 0; i < 14; i++) begin
         run_op(tbl[i], 0);
      end

      // Result held with out_ready low for five cycles
      run_op(mk(16'd100, 8'd7, 16'd14, 8'd2, 1'b0, 1'b0), 5);

      // Reset during the fifth CALC cycle aborts the operation
      @(negedge clk);
      dividend = 16'd100;
      divisor  = 8'd7;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("calc_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_quotient", 32'(quotient), 32'd0);
      seen = 0;
      repeat (25) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("abort_no_result", 32'(seen), 32'd0);

      // Exact divisions: (a*b)/b == a with zero remainder
      for (int k = 0; k < 1000; k++) begin
         sa   = 8'($urandom_range(0, 255));
         sb   = 8'($urandom_range(1, 255));
         prod = sa * sb;
         run_op(mk(prod, sb, {{8{sa[7]}}, sa}, 8'h00, 1'b0, 1'b0), 0);
      end

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
